// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared types and constants for the countdown game round sequencer
// Purpose: state encoding, display source encoding, score ceiling and the
// 21-bit time type used by game_round_ctrl and its test environment.
// Ports: none (package).

package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READY  = 3'd1,
        ST_RUN    = 3'd2,
        ST_PAUSED = 3'd3,
        ST_OVER   = 3'd4
    } game_state_t;

    typedef enum logic [1:0] {
        DISP_TIME  = 2'd0,
        DISP_SCORE = 2'd1,
        DISP_READY = 2'd2
    } disp_sel_t;

    localparam int TIME_W  = 21;
    localparam int TIME_MAX = 2097151;
    localparam int SCORE_W = 14;
    localparam logic [SCORE_W-1:0] SCORE_MAX = 14'd9999;

    typedef logic [TIME_W-1:0] time_t;

    // Subtract with a floor of zero; the budget never wraps.
    function automatic time_t sat_sub(input time_t a, input time_t b);
        return (a > b) ? (a - b) : '0;
    endfunction

endpackage

// File: rtl/game_round_ctrl_tick_prescaler.sv
// rtl/game_round_ctrl_tick_prescaler.sv - free-running tick prescaler with hold and clear
// Purpose: counts 0..TICK_DIV-1 while run is high and strobes tick on the
// last count. The count is held (not cleared) while run is low so a pause
// keeps its phase; clear forces the count back to zero.
// Ports:
//   clock  in  system clock
//   reset  in  synchronous active-high reset
//   run    in  advance the count this cycle
//   clear  in  force the count to zero (wins over run)
//   tick   out high while running with the count at TICK_DIV-1

module tick_prescaler #(
    parameter int TICK_DIV = 5000
) (
    input  logic clock,
    input  logic reset,
    input  logic run,
    input  logic clear,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (run) begin
            count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Decoded from registers only; run comes from the registered game state.
    assign tick = run && (count_q == LAST);

endmodule

// File: rtl/game_round_ctrl.sv
// rtl/game_round_ctrl.sv - round sequencer for the countdown game
// Purpose: owns the time budget, the ready countdown, score and miss
// counters, the game state machine and the registered display source.
// Optional feature macro: GAME_PAUSE_EN (compiles in PAUSED and the pause input).
// Ports:
//   clock       in   system clock
//   reset       in   synchronous active-high reset
//   start       in   pulse: begin or restart a round (IDLE/OVER)
//   pause       in   pulse: toggle pause (RUN/PAUSED, GAME_PAUSE_EN only)
//   hit         in   pulse: score event (RUN only)
//   miss        in   pulse: penalty event (RUN only)
//   state       out  IDLE=0 READY=1 RUN=2 PAUSED=3 OVER=4
//   time_left   out  remaining budget in ticks
//   score       out  hit count, saturating at 9999
//   disp_value  out  value for the display block
//   disp_sel    out  0 time, 1 score, 2 ready countdown
//   tick        out  prescaler strobe
//   game_over   out  high while in OVER

module game_round_ctrl
    import game_pkg::*;
#(
    parameter int TICK_DIV      = 5000,
    parameter int ROUND_TICKS   = 1800000,
    parameter int READY_TICKS   = 30000,
    parameter int PENALTY_TICKS = 50000,
    parameter int MISS_LIMIT    = 3
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic                pause,
    input  logic                hit,
    input  logic                miss,
    output logic [2:0]          state,
    output logic [TIME_W-1:0]   time_left,
    output logic [SCORE_W-1:0]  score,
    output logic [TIME_W-1:0]   disp_value,
    output logic [1:0]          disp_sel,
    output logic                tick,
    output logic                game_over
);

    if (ROUND_TICKS > TIME_MAX || READY_TICKS > TIME_MAX || PENALTY_TICKS >= TIME_MAX) begin : g_bad_width
        $error("game_round_ctrl: tick parameters exceed the 21-bit time range");
    end

    localparam int MW = $clog2(MISS_LIMIT + 1);
    localparam time_t ROUND_T = TIME_W'(ROUND_TICKS);
    localparam time_t READY_T = TIME_W'(READY_TICKS);
    localparam time_t PEN_T   = TIME_W'(PENALTY_TICKS);
    localparam logic [MW-1:0] MISS_LIM = MW'(MISS_LIMIT);

    game_state_t          state_q, state_d;
    time_t                time_q, time_d;
    time_t                ready_q, ready_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [MW-1:0]        misses_q, misses_d;
    time_t                disp_value_q, disp_value_d;
    disp_sel_t            disp_sel_q, disp_sel_d;
    logic                 game_over_q, game_over_d;

    logic                 presc_run;
    logic                 presc_clear;
    logic                 tick_w;
    logic                 terminal;
    time_t                loss;

`ifndef GAME_PAUSE_EN
    logic pause_unused;
    assign pause_unused = pause;
`endif

    assign presc_run = (state_q == ST_READY) || (state_q == ST_RUN);

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_presc (
        .clock (clock),
        .reset (reset),
        .run   (presc_run),
        .clear (presc_clear),
        .tick  (tick_w)
    );

    // Terminal conditions are judged on registered values, so OVER always
    // lands one cycle after time_left shows 0 or misses reaches the limit.
    assign terminal = (time_q == '0) || (misses_q >= MISS_LIM);

    always_comb begin
        state_d     = state_q;
        time_d      = time_q;
        ready_d     = ready_q;
        score_d     = score_q;
        misses_d    = misses_q;
        presc_clear = 1'b0;
        loss        = '0;

        unique case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start) begin
                    state_d     = ST_READY;
                    time_d      = ROUND_T;
                    ready_d     = READY_T;
                    score_d     = '0;
                    misses_d    = '0;
                    presc_clear = 1'b1;
                end
            end
            ST_READY: begin
                if (tick_w) begin
                    ready_d = ready_q - time_t'(1);
                    if (ready_q == time_t'(1)) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (terminal) begin
                    state_d = ST_OVER;
                end else begin
                    loss   = (miss ? PEN_T : '0) + (tick_w ? time_t'(1) : '0);
                    time_d = sat_sub(time_q, loss);
                    if (miss) begin
                        misses_d = misses_q + 1'b1;
                    end
                    if (hit && (score_q != SCORE_MAX)) begin
                        score_d = score_q + 1'b1;
                    end
`ifdef GAME_PAUSE_EN
                    if (pause) begin
                        state_d = ST_PAUSED;
                    end
`endif
                end
            end
            ST_PAUSED: begin
`ifdef GAME_PAUSE_EN
                if (pause) begin
                    state_d = ST_RUN;
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Display source follows the next state so it is registered alongside it.
    always_comb begin
        disp_sel_d   = DISP_TIME;
        disp_value_d = time_d;
        game_over_d  = (state_d == ST_OVER);
        if (state_d == ST_READY) begin
            disp_sel_d   = DISP_READY;
            disp_value_d = ready_d;
        end else if (state_d == ST_OVER) begin
            disp_sel_d   = DISP_SCORE;
            disp_value_d = time_t'(score_d);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            time_q       <= ROUND_T;
            ready_q      <= READY_T;
            score_q      <= '0;
            misses_q     <= '0;
            disp_value_q <= ROUND_T;
            disp_sel_q   <= DISP_TIME;
            game_over_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            time_q       <= time_d;
            ready_q      <= ready_d;
            score_q      <= score_d;
            misses_q     <= misses_d;
            disp_value_q <= disp_value_d;
            disp_sel_q   <= disp_sel_d;
            game_over_q  <= game_over_d;
        end
    end

    assign state      = state_q;
    assign time_left  = time_q;
    assign score      = score_q;
    assign disp_value = disp_value_q;
    assign disp_sel   = disp_sel_q;
    assign tick       = tick_w;
    assign game_over  = game_over_q;

endmodule

// File: tb/tb_game_round_ctrl.sv
// tb/tb_game_round_ctrl.sv - scoreboard bench for game_round_ctrl
module tb_game_round_ctrl;

    localparam int TD  = 4;
    localparam int RT  = 20;
    localparam int RDY = 3;
    localparam int PEN = 5;
    localparam int ML  = 3;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset = 1'b1, start = 1'b0, pause = 1'b0, hit = 1'b0, miss = 1'b0;
    logic [2:0]  state;
    logic [20:0] time_left, disp_value;
    logic [13:0] score;
    logic [1:0]  disp_sel;
    logic        tick, game_over;

    logic        s_reset = 1'b1, s_start = 1'b0, s_hit = 1'b0;
    logic [2:0]  s_state;
    logic [20:0] s_time_left, s_disp_value;
    logic [13:0] s_score;
    logic [1:0]  s_disp_sel;
    logic        s_tick, s_game_over;

    game_round_ctrl #(
        .TICK_DIV(TD), .ROUND_TICKS(RT), .READY_TICKS(RDY),
        .PENALTY_TICKS(PEN), .MISS_LIMIT(ML)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .pause(pause), .hit(hit), .miss(miss),
        .state(state), .time_left(time_left), .score(score), .disp_value(disp_value),
        .disp_sel(disp_sel), .tick(tick), .game_over(game_over)
    );

    // Long-budget instance used only to reach the score ceiling.
    game_round_ctrl #(
        .TICK_DIV(TD), .ROUND_TICKS(2000000), .READY_TICKS(1),
        .PENALTY_TICKS(PEN), .MISS_LIMIT(ML)
    ) u_sat (
        .clock(clock), .reset(s_reset), .start(s_start), .pause(1'b0), .hit(s_hit), .miss(1'b0),
        .state(s_state), .time_left(s_time_left), .score(s_score), .disp_value(s_disp_value),
        .disp_sel(s_disp_sel), .tick(s_tick), .game_over(s_game_over)
    );

    typedef struct {
        int st; int tl; int sc; int dv; int ds; int tk; int go;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    // Reference model: game state as plain integers.
    int m_st, m_tl, m_sc, m_mi, m_rd, m_ph;

    task automatic cmp(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_step(input bit r, input bit s, input bit p, input bit h, input bit m);
        bit tk;
        int loss;
        if (r) begin
            m_st = 0; m_tl = RT; m_sc = 0; m_mi = 0; m_rd = RDY; m_ph = 0;
            return;
        end
        tk = (m_ph == TD - 1);
        case (m_st)
            0, 4: begin
                if (s) begin
                    m_st = 1; m_rd = RDY; m_tl = RT; m_sc = 0; m_mi = 0; m_ph = 0;
                end
            end
            1: begin
                m_ph = (m_ph + 1) % TD;
                if (tk) begin
                    if (m_rd == 1) m_st = 2;
                    m_rd = m_rd - 1;
                end
            end
            2: begin
                m_ph = (m_ph + 1) % TD;
                if (m_tl == 0 || m_mi >= ML) begin
                    m_st = 4;
                end else begin
                    loss = (tk ? 1 : 0) + (m ? PEN : 0);
                    m_tl = (m_tl > loss) ? m_tl - loss : 0;
                    if (m) m_mi = m_mi + 1;
                    if (h && m_sc < 9999) m_sc = m_sc + 1;
`ifdef GAME_PAUSE_EN
                    if (p) m_st = 3;
`endif
                end
            end
            3: begin
`ifdef GAME_PAUSE_EN
                if (p) m_st = 2;
`endif
            end
            default: m_st = 0;
        endcase
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.st = m_st;
        e.tl = m_tl;
        e.sc = m_sc;
        e.ds = (m_st == 1) ? 2 : ((m_st == 4) ? 1 : 0);
        e.dv = (m_st == 1) ? m_rd : ((m_st == 4) ? m_sc : m_tl);
        e.tk = ((m_st == 1 || m_st == 2) && m_ph == TD - 1) ? 1 : 0;
        e.go = (m_st == 4) ? 1 : 0;
        return e;
    endfunction

    task automatic step(input bit r, input bit s, input bit p, input bit h, input bit m);
        @(negedge clock);
        reset = r; start = s; pause = p; hit = h; miss = m;
        model_step(r, s, p, h, m);
        exp_q.push_back(model_out());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    task automatic after_edge();
        @(posedge clock);
        #2;
    endtask

    task automatic sat_cycle(input bit sr, input bit ss, input bit sh);
        step(0, 0, 0, 0, 0);
        s_reset = sr; s_start = ss; s_hit = sh;
    endtask

    always @(posedge clock) begin : monitor
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cmp("state", int'(state), e.st);
            cmp("time_left", int'(time_left), e.tl);
            cmp("score", int'(score), e.sc);
            cmp("disp_value", int'(disp_value), e.dv);
            cmp("disp_sel", int'(disp_sel), e.ds);
            cmp("tick", int'(tick), e.tk);
            cmp("game_over", int'(game_over), e.go);
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        bit seen_run;
        repeat (3) step(1, 0, 0, 0, 0);
        after_edge();
        cmp("rst_state", int'(state), 0);
        cmp("rst_time", int'(time_left), RT);
        cmp("rst_disp_value", int'(disp_value), RT);
        cmp("rst_tick", int'(tick), 0);

        // Full round
        step(0, 1, 0, 0, 0);
        after_edge();
        cmp("ready_entry_dv", int'(disp_value), 3);
        cmp("ready_entry_sel", int'(disp_sel), 2);
        idle(12);
        after_edge();
        cmp("run_after_12", int'(state), 2);
        idle(80);
        after_edge();
        cmp("time_zero", int'(time_left), 0);
        cmp("still_run", int'(state), 2);
        idle(1);
        after_edge();
        cmp("over_state", int'(state), 4);
        cmp("over_flag", int'(game_over), 1);
        step(0, 0, 0, 1, 1);
        after_edge();
        cmp("over_ignores_hit", int'(score), 0);

        // Penalty and miss limit
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        idle(20);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        after_edge();
        cmp("two_miss_time", int'(time_left), 8);
        step(0, 0, 0, 0, 1);
        after_edge();
        cmp("third_miss_time", int'(time_left), 3);
        idle(1);
        after_edge();
        cmp("miss_limit_over", int'(state), 4);

        // Miss coinciding with tick saturates to zero
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        idle(79);
        step(0, 0, 0, 0, 1);
        after_edge();
        cmp("sat_time", int'(time_left), 0);
        cmp("sat_state_run", int'(state), 2);
        idle(1);
        after_edge();
        cmp("sat_over", int'(state), 4);

        // Events in READY ignored, start in RUN ignored
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 1);
        after_edge();
        cmp("ready_ignore_score", int'(score), 0);
        cmp("ready_ignore_time", int'(time_left), RT);
        idle(11);
        step(0, 1, 0, 0, 0);
        after_edge();
        cmp("run_start_ignored", int'(time_left), RT);

        // Reset mid-RUN
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        idle(12);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0);
        idle(47);
        after_edge();
        cmp("pre_reset_time", int'(time_left), 7);
        cmp("pre_reset_score", int'(score), 5);
        step(1, 0, 0, 0, 0);
        after_edge();
        cmp("mid_reset_state", int'(state), 0);
        cmp("mid_reset_time", int'(time_left), RT);
        cmp("mid_reset_score", int'(score), 0);
        cmp("mid_reset_tick", int'(tick), 0);

`ifdef GAME_PAUSE_EN
        step(0, 1, 0, 0, 0);
        idle(14);
        step(0, 0, 1, 0, 0);
        after_edge();
        cmp("paused_state", int'(state), 3);
        for (int i = 0; i < 50; i++) step(0, 0, 0, 1, 1);
        after_edge();
        cmp("paused_time", int'(time_left), RT);
        cmp("paused_score", int'(score), 0);
        step(0, 0, 1, 0, 0);
        after_edge();
        cmp("resume_tick", int'(tick), 1);
        idle(1);
        after_edge();
        cmp("resume_time", int'(time_left), RT - 1);
        step(1, 0, 0, 0, 0);
`endif

        // Score ceiling on the long-budget instance
        sat_cycle(0, 1, 0);
        seen_run = 0;
        for (int i = 0; i < 20 && !seen_run; i++) begin
            sat_cycle(0, 0, 0);
            after_edge();
            if (s_state == 3'd2) seen_run = 1;
        end
        cmp("sat_reached_run", int'(seen_run), 1);
        for (int i = 0; i < 9998; i++) sat_cycle(0, 0, 1);
        after_edge();
        cmp("score_9998", int'(s_score), 9998);
        for (int i = 0; i < 7; i++) sat_cycle(0, 0, 1);
        after_edge();
        cmp("score_ceiling", int'(s_score), 9999);
        sat_cycle(1, 0, 0);

        // Randomized traffic
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 99) < 3,
                 $urandom_range(0, 99) < 5,
                 $urandom_range(0, 99) < 25,
                 $urandom_range(0, 99) < 6);
        end
        idle(1);
        repeat (3) @(posedge clock);
        #3;
        cmp("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
